// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
//   op_t    - operation select carried on the op port
//   state_t - sequencer state (IDLE -> RUN -> FIX -> IDLE)
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide with HI/LO
// result registers for the multi-cycle MIPS datapath.
//
// Handshake: start is sampled only while busy=0. The edge that accepts start
// raises busy; busy stays high for N+1 cycles. On the edge that drops busy,
// hi/lo are written and done pulses for exactly one cycle. start while busy
// is ignored (no queuing). MTHI/MTLO writes land only when idle and start=0.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   start, op, A, B - launch request, operation (op_t), operands
//   wr_hi, wr_lo    - MTHI/MTLO strobes, data on wdata
//   busy, done      - operation in progress / one-cycle completion pulse
//   hi, lo          - result registers (product high/low, remainder/quotient)
//   divz            - last division had a zero divisor; cleared by next start
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         divz
);

    localparam int CW = $clog2(N);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_q;     // product sign (mult) or quotient sign (div)
    logic            neg_r;     // remainder sign, follows the dividend
    logic [N-1:0]    a_orig;    // raw dividend, returned as HI on divide by zero
    logic [N-1:0]    b_mag;     // multiplicand or divisor magnitude
    logic [2*N-1:0]  acc;       // {partial product | remainder, multiplier | quotient}

    // Operand magnitudes for launch
    logic            is_signed_in, is_div_in, a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag_in;

    always_comb begin
        is_signed_in = (op == OP_MULT) || (op == OP_DIV);
        is_div_in    = (op == OP_DIV)  || (op == OP_DIVU);
        a_neg        = is_signed_in & A[N-1];
        b_neg        = is_signed_in & B[N-1];
        a_mag        = a_neg ? (~A + 1'b1) : A;
        b_mag_in     = b_neg ? (~B + 1'b1) : B;
    end

    // One shared N+1 bit adder: add-or-zero for multiply, subtract for divide.
    logic [N:0]      add_x, add_y, add_sum;
    logic            q_bit;
    logic [2*N-1:0]  step_acc;

    always_comb begin
        add_x    = is_div ? {acc[2*N-1:N], acc[N-1]} : {1'b0, acc[2*N-1:N]};
        add_y    = is_div ? ~{1'b0, b_mag} : (acc[0] ? {1'b0, b_mag} : '0);
        add_sum  = add_x + add_y + {{N{1'b0}}, is_div};
        // Top bit clear means the trial subtraction did not underflow.
        q_bit    = ~add_sum[N];
        step_acc = {add_sum, acc[N-1:1]};
        if (is_div) begin
            step_acc = {(q_bit ? add_sum[N-1:0] : add_x[N-1:0]), acc[N-2:0], q_bit};
        end
    end

    // Sign correction and divide-by-zero substitution applied in FIX
    logic [2*N-1:0]  prod;
    logic [N-1:0]    fix_hi, fix_lo;
    logic            fix_divz;

    always_comb begin
        prod     = neg_q ? (~acc + 1'b1) : acc;
        fix_divz = is_div && (b_mag == '0);
        fix_hi   = prod[2*N-1:N];
        fix_lo   = prod[N-1:0];
        if (is_div) begin
            fix_lo = neg_q ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
            fix_hi = neg_r ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];
        end
        if (fix_divz) begin
            fix_lo = '1;
            fix_hi = a_orig;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_orig <= '0;
            b_mag  <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            divz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= is_div_in;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        a_orig <= A;
                        b_mag  <= b_mag_in;
                        acc    <= {{N{1'b0}}, a_mag};
                        cnt    <= CW'(N - 1);
                        divz   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= step_acc;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    divz  <= fix_divz;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit. The driver pushes the
// hand-computed {divz, hi, lo} for each launched operation; a monitor pops and
// compares whenever done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int N = 32;
    localparam int W = 2 * N + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a_s = '0;
    logic [N-1:0] b_s = '0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [N-1:0] wdata = '0;
    logic         busy, done, divz;
    logic [N-1:0] hi, lo;

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (a_s),
        .B     (b_s),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .divz  (divz)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [N-1:0] hold_hi, hold_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, required no pulse");
            end else begin
                exp_e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(exp_e[2*N-1:N]));
                check("result_lo", 64'(lo), 64'(exp_e[N-1:0]));
                check("result_divz", 64'(divz), 64'(exp_e[W-1]));
            end
        end
    end

    // Driver tasks (called on a falling edge)
    task automatic start_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] eh, input logic [N-1:0] el, input logic ez);
        hold_hi = hi;
        hold_lo = lo;
        start = 1'b1;
        op    = o;
        a_s   = a;
        b_s   = b;
        exp_q.push_back({ez, eh, el});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("divz_clear_on_start", 64'(divz), 64'd0);
    endtask

    // mode 1: MTLO attempt mid-run; mode 2: second start mid-run
    task automatic wait_idle(input int mode);
        int cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (mode == 1 && cnt == 5) begin wr_lo = 1'b1; wdata = 32'hDEAD_BEEF; end
            if (mode == 1 && cnt == 6) wr_lo = 1'b0;
            if (mode == 2 && cnt == 4) begin start = 1'b1; a_s = 9; b_s = 9; end
            if (mode == 2 && cnt == 5) start = 1'b0;
            if (cnt == 10) begin
                check("hold_hi_in_run", 64'(hi), 64'(hold_hi));
                check("hold_lo_in_run", 64'(lo), 64'(hold_lo));
            end
            @(negedge clk);
        end
        if (cnt >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL busy_timeout: busy still high after %0d cycles, required %0d", cnt, N + 1);
        end else begin
            check("busy_cycles", 64'(cnt), 64'(N + 1));
            check("done_latency", 64'(done), 64'd1);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eh, input logic [N-1:0] el, input logic ez);
        start_op(o, a, b, eh, el, ez);
        wait_idle(0);
    endtask

    // Stimulus
    initial begin
        #1 reset = 1'b1;
        #2;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_divz", 64'(divz), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1);
        repeat (3) @(negedge clk);
        check("divz_holds_idle", 64'(divz), 64'd1);
        run_op(OP_MULTU, 32'd2,         32'd3,        32'd0,         32'd6,         1'b0);

        // MTHI / MTLO while idle
        wr_hi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi_idle_hi", 64'(hi), 64'h1234);
        check("mthi_idle_lo", 64'(lo), 64'd6);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("mthi_mtlo_hi", 64'(hi), 64'hABCD);
        check("mthi_mtlo_lo", 64'(lo), 64'hABCD);

        // Start wins over a same-cycle MTHI
        wr_hi = 1'b1; wdata = 32'h0000_5555;
        start_op(OP_MULTU, 32'd2, 32'd5, 32'd0, 32'd10, 1'b0);
        wr_hi = 1'b0;
        check("mthi_dropped_on_start", 64'(hi), 64'hABCD);
        wait_idle(0);

        // MTLO during busy is ignored
        start_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
        wait_idle(1);

        // Second start while busy is ignored
        start_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        wait_idle(2);
        repeat (5) @(negedge clk);
        check("no_queued_start", 64'(busy), 64'd0);

        // Reset mid-operation discards the operation
        start = 1'b1; op = OP_MULTU; a_s = 3; b_s = 4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midop_reset_busy", 64'(busy), 64'd0);
        check("midop_reset_hi", 64'(hi), 64'd0);
        check("midop_reset_lo", 64'(lo), 64'd0);
        check("midop_reset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midop_reset_idle", 64'(busy), 64'd0);

        run_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
